mem_arbiter: RTL and testbench

Arbiter and sequencer for the single-ported unified instruction/data memory of the RISC-V core. It sits between the fetch stage (instruction-fetch port) and the load/store path driven by the main decoder's `mr`/`mwrite` signals (data port). It serialises their requests onto one fixed-latency memory port and returns read data with a one-cycle completion pulse. It also produces the core-wide stall signal while any request is outstanding.

---
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_arbiter_if                                                        |
// | Fetch, data and memory-side signals of the unified memory arbiter.    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              if_req;
    logic [AW-1:0]     if_addr;
    logic [DW-1:0]     if_rdata;
    logic              if_valid;
    logic              d_req;
    logic              d_we;
    logic [AW-1:0]     d_addr;
    logic [DW-1:0]     d_wdata;
    logic [DW/8-1:0]   d_wstrb;
    logic [DW-1:0]     d_rdata;
    logic              d_done;
    logic              mem_en;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW/8-1:0]   mem_wstrb;
    logic [DW-1:0]     mem_rdata;
    logic              busy;
    logic              stall;

    // The arbiter itself takes the slave view.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
        output if_rdata, if_valid, d_rdata, d_done,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb, busy, stall
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
        input  if_rdata, if_valid, d_rdata, d_done,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb, busy, stall
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_arbiter                                                           |
// | Serialises fetch and load/store onto one fixed-latency memory port.   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int LAT        = 2,
    parameter int DATA_BURST = 2
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mem_arbiter_if.slave      bus
);

    localparam int         c_SW    = DW / 8;
    localparam logic [2:0] c_LAT   = 3'(LAT);
    localparam logic [2:0] c_BURST = 3'(DATA_BURST);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t            state_q,     state_d;
    logic [2:0]        cnt_q,       cnt_d;
    logic [2:0]        streak_q,    streak_d;
    logic              owner_q,     owner_d;      // 1 = data port owns the access
    logic              mem_en_q,    mem_en_d;
    logic              mem_we_q,    mem_we_d;
    logic [AW-1:0]     mem_addr_q,  mem_addr_d;
    logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
    logic [c_SW-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic [DW-1:0]     if_rdata_q,  if_rdata_d;
    logic [DW-1:0]     d_rdata_q,   d_rdata_d;
    logic              if_valid_q,  if_valid_d;
    logic              d_done_q,    d_done_d;
    logic              busy_q,      busy_d;

    logic              w_arb;
    logic              w_grant_data;
    logic              w_grant_fetch;

    // Data wins a tie until it has taken DATA_BURST grants in a row.
    assign w_arb         = (state_q == ST_IDLE) || (state_q == ST_RESP);
    assign w_grant_data  = w_arb && bus.d_req && (!bus.if_req || (streak_q != c_BURST));
    assign w_grant_fetch = w_arb && bus.if_req && !w_grant_data;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        streak_d    = streak_q;
        owner_d     = owner_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_valid_d  = 1'b0;
        d_done_d    = 1'b0;
        busy_d      = busy_q;

        case (state_q)
            ST_IDLE, ST_RESP: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                if (w_grant_data) begin
                    state_d     = ST_ISSUE;
                    busy_d      = 1'b1;
                    mem_en_d    = 1'b1;
                    owner_d     = 1'b1;
                    cnt_d       = c_LAT;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    mem_wstrb_d = bus.d_we ? bus.d_wstrb : '0;
                    streak_d    = (streak_q == c_BURST) ? streak_q : streak_q + 3'd1;
                end else if (w_grant_fetch) begin
                    state_d     = ST_ISSUE;
                    busy_d      = 1'b1;
                    mem_en_d    = 1'b1;
                    owner_d     = 1'b0;
                    cnt_d       = c_LAT;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_wstrb_d = '0;
                    streak_d    = 3'd0;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                // cnt reaching 1 marks the cycle the memory presents read data.
                if (cnt_q <= 3'd1) begin
                    state_d = ST_RESP;
                    busy_d  = 1'b0;
                    if (owner_q) begin
                        d_rdata_d = bus.mem_rdata;
                        d_done_d  = 1'b1;
                    end else begin
                        if_rdata_d = bus.mem_rdata;
                        if_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            streak_q    <= 3'd0;
            owner_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_valid_q  <= 1'b0;
            d_done_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            streak_q    <= streak_d;
            owner_q     <= owner_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_valid_q  <= if_valid_d;
            d_done_q    <= d_done_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_done    = d_done_q;
    assign bus.busy      = busy_q;
    assign bus.stall     = (bus.if_req & ~if_valid_q) | (bus.d_req & ~d_done_q);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_mem_arbiter                                                        |
// | Directed bench for mem_arbiter at LAT = 2, 1 and 7.                   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(32), .DW(32)) b2 ();
    mem_arbiter_if #(.AW(32), .DW(32)) b1 ();
    mem_arbiter_if #(.AW(32), .DW(32)) b7 ();

    mem_arbiter #(.AW(32), .DW(32), .LAT(2), .DATA_BURST(2)) u_dut  (.clk(clk), .rst(rst), .bus(b2));
    mem_arbiter #(.AW(32), .DW(32), .LAT(1), .DATA_BURST(2)) u_lat1 (.clk(clk), .rst(rst), .bus(b1));
    mem_arbiter #(.AW(32), .DW(32), .LAT(7), .DATA_BURST(2)) u_lat7 (.clk(clk), .rst(rst), .bus(b7));

    // Memory contents: 0x10 holds an addi, everything else echoes its address.
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h10) ? 32'h0050_0093 : (32'hC0DE_0000 | {16'h0, a[15:0]});
    endfunction

    // Fixed-latency memories; outside the valid slot they return a poison word.
    logic [32:0] p1;
    logic [32:0] p2 [2];
    logic [32:0] p7 [7];

    always @(posedge clk) begin
        if (rst) begin
            p1 <= '0;
            p2[0] <= '0;
            p2[1] <= '0;
            for (int k = 0; k < 7; k++) p7[k] <= '0;
        end else begin
            p1    <= {b1.mem_en, mem_val(b1.mem_addr)};
            p2[0] <= {b2.mem_en, mem_val(b2.mem_addr)};
            p2[1] <= p2[0];
            p7[0] <= {b7.mem_en, mem_val(b7.mem_addr)};
            for (int k = 1; k < 7; k++) p7[k] <= p7[k-1];
        end
    end

    assign b1.mem_rdata = p1[32]    ? p1[31:0]    : 32'hBAAD_F00D;
    assign b2.mem_rdata = p2[1][32] ? p2[1][31:0] : 32'hBAAD_F00D;
    assign b7.mem_rdata = p7[6][32] ? p7[6][31:0] : 32'hBAAD_F00D;

    task automatic test_reset();
        rst = 1'b1;
        b2.if_req = 1'b1; b2.if_addr = 32'h10; b2.d_req = 1'b1; b2.d_addr = 32'h100;
        repeat (3) @(posedge clk);
        #2;
        checks++; if (b2.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", b2.busy); end
        checks++; if (b2.mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got %b exp 0", b2.mem_en); end
        checks++; if (b2.if_valid !== 1'b0 || b2.d_done !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b exp 00", b2.if_valid, b2.d_done); end
        checks++; if (b2.if_rdata !== 32'h0 || b2.d_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h %h exp 0 0", b2.if_rdata, b2.d_rdata); end
        checks++; if (b2.mem_wstrb !== 4'h0 || b2.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem got %h %h exp 0 0", b2.mem_wstrb, b2.mem_addr); end
        checks++; if (b2.stall !== 1'b1) begin errors++; $display("FAIL reset_stall got %b exp 1", b2.stall); end
        b2.if_req = 1'b0; b2.d_req = 1'b0;
        rst = 1'b0;
        @(posedge clk); #2;
    endtask

    task automatic test_single_fetch();
        @(posedge clk); #1;
        b2.if_req = 1'b1; b2.if_addr = 32'h10;
        #1;
        for (int c = 0; c < 7; c++) begin
            checks++; if (b2.mem_en !== 1'(c == 1)) begin errors++; $display("FAIL fetch_mem_en cyc %0d got %b exp %b", c, b2.mem_en, c == 1); end
            checks++; if (b2.if_valid !== 1'(c == 4)) begin errors++; $display("FAIL fetch_valid cyc %0d got %b exp %b", c, b2.if_valid, c == 4); end
            checks++; if (b2.stall !== 1'(c <= 3)) begin errors++; $display("FAIL fetch_stall cyc %0d got %b exp %b", c, b2.stall, c <= 3); end
            if (c == 1) begin
                checks++; if (b2.mem_addr !== 32'h10 || b2.mem_we !== 1'b0 || b2.mem_wstrb !== 4'h0) begin
                    errors++; $display("FAIL fetch_issue got addr %h we %b strb %h exp 10 0 0", b2.mem_addr, b2.mem_we, b2.mem_wstrb); end
            end
            if (c == 4) begin
                checks++; if (b2.if_rdata !== 32'h0050_0093) begin errors++; $display("FAIL fetch_rdata got %h exp 00500093", b2.if_rdata); end
                b2.if_req = 1'b0;
            end
            @(posedge clk); #2;
        end
    endtask

    task automatic test_store();
        @(posedge clk); #1;
        b2.d_req = 1'b1; b2.d_we = 1'b1; b2.d_addr = 32'h100; b2.d_wdata = 32'hDEAD_BEEF; b2.d_wstrb = 4'hF;
        #1;
        for (int c = 0; c < 6; c++) begin
            checks++; if (b2.mem_en !== 1'(c == 1)) begin errors++; $display("FAIL store_mem_en cyc %0d got %b exp %b", c, b2.mem_en, c == 1); end
            checks++; if (b2.d_done !== 1'(c == 4)) begin errors++; $display("FAIL store_done cyc %0d got %b exp %b", c, b2.d_done, c == 4); end
            checks++; if (b2.busy !== 1'(c >= 1 && c <= 3)) begin errors++; $display("FAIL store_busy cyc %0d got %b exp %b", c, b2.busy, c >= 1 && c <= 3); end
            if (c == 1) begin
                checks++; if (b2.mem_we !== 1'b1 || b2.mem_addr !== 32'h100 || b2.mem_wdata !== 32'hDEAD_BEEF || b2.mem_wstrb !== 4'hF) begin
                    errors++; $display("FAIL store_issue got we %b addr %h data %h strb %h exp 1 100 deadbeef f", b2.mem_we, b2.mem_addr, b2.mem_wdata, b2.mem_wstrb); end
            end
            if (c == 4) begin b2.d_req = 1'b0; b2.d_we = 1'b0; end
            @(posedge clk); #2;
        end
    endtask

    task automatic test_simultaneous();
        @(posedge clk); #1;
        b2.if_req = 1'b1; b2.if_addr = 32'h20;
        b2.d_req = 1'b1; b2.d_we = 1'b0; b2.d_addr = 32'h200; b2.d_wstrb = 4'h0;
        #1;
        for (int c = 0; c < 10; c++) begin
            checks++; if (b2.d_done !== 1'(c == 4)) begin errors++; $display("FAIL simul_d_done cyc %0d got %b exp %b", c, b2.d_done, c == 4); end
            checks++; if (b2.if_valid !== 1'(c == 8)) begin errors++; $display("FAIL simul_if_valid cyc %0d got %b exp %b", c, b2.if_valid, c == 8); end
            checks++; if (b2.stall !== 1'(c <= 7)) begin errors++; $display("FAIL simul_stall cyc %0d got %b exp %b", c, b2.stall, c <= 7); end
            if (c == 1 || c == 5) begin
                checks++; if (b2.mem_wstrb !== 4'h0 || b2.mem_addr !== ((c == 1) ? 32'h200 : 32'h20)) begin
                    errors++; $display("FAIL simul_issue cyc %0d got addr %h strb %h", c, b2.mem_addr, b2.mem_wstrb); end
            end
            if (c == 4) begin
                checks++; if (b2.d_rdata !== 32'hC0DE_0200) begin errors++; $display("FAIL simul_d_rdata got %h exp c0de0200", b2.d_rdata); end
                b2.d_req = 1'b0;
            end
            if (c == 8) begin
                checks++; if (b2.if_rdata !== 32'hC0DE_0020) begin errors++; $display("FAIL simul_if_rdata got %h exp c0de0020", b2.if_rdata); end
                b2.if_req = 1'b0;
            end
            @(posedge clk); #2;
        end
    endtask

    task automatic test_contention();
        logic [7:0] order [6];
        logic [7:0] exp_order [6];
        int         grants = 0;
        exp_order[0] = "D"; exp_order[1] = "D"; exp_order[2] = "F";
        exp_order[3] = "D"; exp_order[4] = "D"; exp_order[5] = "F";
        @(posedge clk); #1;
        b2.if_req = 1'b1; b2.if_addr = 32'h1000;
        b2.d_req = 1'b1; b2.d_we = 1'b0; b2.d_addr = 32'h2000;
        #1;
        for (int c = 0; c < 60 && grants < 6; c++) begin
            checks++; if (b2.if_valid === 1'b1 && b2.d_done === 1'b1) begin errors++; $display("FAIL burst_both_done cyc %0d", c); end
            if (b2.mem_en === 1'b1) begin
                order[grants] = (b2.mem_addr >= 32'h2000) ? 8'("D") : 8'("F");
                grants++;
            end
            if (b2.if_valid === 1'b1) begin
                checks++; if (b2.if_rdata !== (32'hC0DE_0000 | b2.if_addr)) begin errors++; $display("FAIL burst_if_rdata got %h exp %h", b2.if_rdata, 32'hC0DE_0000 | b2.if_addr); end
                b2.if_addr = b2.if_addr + 32'd4;
            end
            if (b2.d_done === 1'b1) begin
                checks++; if (b2.d_rdata !== (32'hC0DE_0000 | b2.d_addr)) begin errors++; $display("FAIL burst_d_rdata got %h exp %h", b2.d_rdata, 32'hC0DE_0000 | b2.d_addr); end
                b2.d_addr = b2.d_addr + 32'd4;
            end
            if (grants < 6) begin @(posedge clk); #2; end
        end
        b2.if_req = 1'b0; b2.d_req = 1'b0;
        checks++; if (grants != 6) begin errors++; $display("FAIL burst_timeout got %0d grants exp 6", grants); end
        for (int i = 0; i < grants; i++) begin
            checks++; if (order[i] !== exp_order[i]) begin errors++; $display("FAIL burst_order slot %0d got %c exp %c", i, order[i], exp_order[i]); end
        end
        repeat (8) @(posedge clk);
        #2;
    endtask

    task automatic test_reset_mid_wait();
        @(posedge clk); #1;
        b2.d_req = 1'b1; b2.d_we = 1'b0; b2.d_addr = 32'h300;
        #1;
        @(posedge clk); #2;
        @(posedge clk); #2;
        checks++; if (b2.busy !== 1'b1) begin errors++; $display("FAIL rstwait_busy_before got %b exp 1", b2.busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; b2.d_req = 1'b0;
        #1;
        checks++; if (b2.busy !== 1'b0) begin errors++; $display("FAIL rstwait_busy got %b exp 0", b2.busy); end
        checks++; if (b2.d_rdata !== 32'h0) begin errors++; $display("FAIL rstwait_d_rdata got %h exp 0", b2.d_rdata); end
        checks++; if (b2.mem_en !== 1'b0) begin errors++; $display("FAIL rstwait_mem_en got %b exp 0", b2.mem_en); end
        for (int c = 0; c < 5; c++) begin
            checks++; if (b2.d_done !== 1'b0 || b2.busy !== 1'b0) begin errors++; $display("FAIL rstwait_quiet cyc %0d got done %b busy %b exp 0 0", c, b2.d_done, b2.busy); end
            @(posedge clk); #2;
        end
        b2.d_req = 1'b1; b2.d_addr = 32'h304;
        for (int c = 0; c < 6; c++) begin
            checks++; if (b2.d_done !== 1'(c == 4)) begin errors++; $display("FAIL rstwait_reissue cyc %0d got %b exp %b", c, b2.d_done, c == 4); end
            if (c == 4) begin
                checks++; if (b2.d_rdata !== 32'hC0DE_0304) begin errors++; $display("FAIL rstwait_rdata got %h exp c0de0304", b2.d_rdata); end
                b2.d_req = 1'b0;
            end
            @(posedge clk); #2;
        end
    endtask

    task automatic test_lat_sweep();
        @(posedge clk); #1;
        b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 32'h40;
        b7.if_req = 1'b1; b7.if_addr = 32'h80;
        #1;
        for (int c = 0; c < 12; c++) begin
            checks++; if (b1.mem_en !== 1'(c == 1) || b7.mem_en !== 1'(c == 1)) begin errors++; $display("FAIL sweep_mem_en cyc %0d got %b %b", c, b1.mem_en, b7.mem_en); end
            checks++; if (b1.d_done !== 1'(c == 3)) begin errors++; $display("FAIL lat1_done cyc %0d got %b exp %b", c, b1.d_done, c == 3); end
            checks++; if (b7.if_valid !== 1'(c == 9)) begin errors++; $display("FAIL lat7_valid cyc %0d got %b exp %b", c, b7.if_valid, c == 9); end
            if (c == 3) begin
                checks++; if (b1.d_rdata !== 32'hC0DE_0040) begin errors++; $display("FAIL lat1_rdata got %h exp c0de0040", b1.d_rdata); end
                b1.d_req = 1'b0;
            end
            if (c == 9) begin
                checks++; if (b7.if_rdata !== 32'hC0DE_0080) begin errors++; $display("FAIL lat7_rdata got %h exp c0de0080", b7.if_rdata); end
                b7.if_req = 1'b0;
            end
            @(posedge clk); #2;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        b1.if_req = 1'b0; b1.if_addr = '0; b1.d_req = 1'b0; b1.d_we = 1'b0; b1.d_addr = '0; b1.d_wdata = '0; b1.d_wstrb = '0;
        b2.if_req = 1'b0; b2.if_addr = '0; b2.d_req = 1'b0; b2.d_we = 1'b0; b2.d_addr = '0; b2.d_wdata = '0; b2.d_wstrb = '0;
        b7.if_req = 1'b0; b7.if_addr = '0; b7.d_req = 1'b0; b7.d_we = 1'b0; b7.d_addr = '0; b7.d_wdata = '0; b7.d_wstrb = '0;
        test_reset();
        test_single_fetch();
        test_store();
        test_simultaneous();
        test_contention();
        test_reset_mid_wait();
        test_lat_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
